// File: rtl/replay_write_sequencer_pkg.sv
// Shared types and width helper for the replay buffer write-side sequencer.
package replay_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } rseq_state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/replay_write_sequencer_edge_gate.sv
// Per-line first-spike detector: rising-edge detect, once-per-window fired mask,
// and the OR-reduced "edge seen while holding" indication.
module spike_edge_gate #(
    parameter int P = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en_cap,
    input  logic         en_hold,
    input  logic [P-1:0] spk,
    output logic [P-1:0] pulse,
    output logic         late_hit
);

    logic [P-1:0] s_prev;
    logic [P-1:0] fired;
    logic [P-1:0] edge_v;

    assign edge_v   = spk & ~s_prev;
    assign pulse    = edge_v & ~fired & {P{en_cap}};
    assign late_hit = en_hold & (|edge_v);

    // NOTE: the fired mask is a plain flop vector, not a RAM, so it takes the reset
    // like any other state and is also cleared every cycle spent idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev <= '0;
            fired  <= '0;
        end else begin
            s_prev <= spk;
            if (clr) begin
                fired <= '0;
            end else begin
                fired <= fired | pulse;
            end
        end
    end

endmodule

// File: rtl/replay_write_sequencer.sv
// Write-side sequencer for the replay buffer: gamma-framed capture FSM, slot counter,
// first-spike pulses for two sources. Optional input synchronizer: REPLAY_SEQ_SPIKE_SYNC_EN.
module replay_write_sequencer
    import replay_pkg::*;
#(
    parameter  int P            = 64,
    parameter  int BUFFER_DEPTH = 16,
    localparam int IDX_W        = idx_w(BUFFER_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grst,
    input  logic [P-1:0]     spk_a,
    input  logic [P-1:0]     spk_b,
    output logic [IDX_W-1:0] wr_idx,
    output logic             start_count,
    output logic [P-1:0]     data_in1,
    output logic [P-1:0]     data_in2,
    output logic             buf_sel,
    output logic             short_err,
    output logic             late_err
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(BUFFER_DEPTH - 1);

    rseq_state_t      state;
    logic [IDX_W-1:0] cnt;
    logic             grst_q;
    logic             fall;
    logic             rise;
    logic [P-1:0]     s_a;
    logic [P-1:0]     s_b;
    logic [P-1:0]     pulse_a;
    logic [P-1:0]     pulse_b;
    logic             late_a;
    logic             late_b;

    assign fall = grst_q & ~grst;
    assign rise = ~grst_q & grst;

`ifdef REPLAY_SEQ_SPIKE_SYNC_EN
    logic [P-1:0] a_meta, a_sync, b_meta, b_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta <= '0;
            a_sync <= '0;
            b_meta <= '0;
            b_sync <= '0;
        end else begin
            a_meta <= spk_a;
            a_sync <= a_meta;
            b_meta <= spk_b;
            b_sync <= b_meta;
        end
    end

    assign s_a = a_sync;
    assign s_b = b_sync;
`else
    assign s_a = spk_a;
    assign s_b = spk_b;
`endif

    spike_edge_gate #(.P(P)) u_gate_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en_cap   (state == CAPTURE),
        .en_hold  (state == HOLD),
        .spk      (s_a),
        .pulse    (pulse_a),
        .late_hit (late_a)
    );

    spike_edge_gate #(.P(P)) u_gate_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en_cap   (state == CAPTURE),
        .en_hold  (state == HOLD),
        .spk      (s_b),
        .pulse    (pulse_b),
        .late_hit (late_b)
    );

    // NOTE: every state/output register below uses <= so all of them see the
    // pre-edge values of state and cnt, which is what pairs a pulse with its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            grst_q      <= 1'b0;
            start_count <= 1'b0;
            buf_sel     <= 1'b0;
            short_err   <= 1'b0;
        end else begin
            grst_q <= grst;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state       <= CAPTURE;
                        cnt         <= '0;
                        start_count <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // A rise on the last slot is a normal completion, not a short window.
                    if (rise) begin
                        state       <= IDLE;
                        start_count <= 1'b0;
                        buf_sel     <= ~buf_sel;
                        if (cnt != LAST_SLOT) begin
                            short_err <= 1'b1;
                        end
                    end else if (cnt == LAST_SLOT) begin
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (rise) begin
                        state       <= IDLE;
                        start_count <= 1'b0;
                        buf_sel     <= ~buf_sel;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_count <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx   <= '0;
            data_in1 <= '0;
            data_in2 <= '0;
            late_err <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                wr_idx <= cnt;
            end
            data_in1 <= pulse_a;
            data_in2 <= pulse_b;
            if (late_a | late_b) begin
                late_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_replay_write_sequencer.sv
// Directed bench for replay_write_sequencer; expected slot indices shift by two
// when REPLAY_SEQ_SPIKE_SYNC_EN is defined.
module tb_replay_write_sequencer;

    localparam int P     = 64;
    localparam int IDX_W = 5;
`ifdef REPLAY_SEQ_SPIKE_SYNC_EN
    localparam int E = 2;
`else
    localparam int E = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             grst;
    logic [P-1:0]     spk_a;
    logic [P-1:0]     spk_b;
    logic [IDX_W-1:0] wr_idx;
    logic             start_count;
    logic [P-1:0]     data_in1;
    logic [P-1:0]     data_in2;
    logic             buf_sel;
    logic             short_err;
    logic             late_err;

    int n_cmp = 0;
    int n_err = 0;
    int slot  = 0;

    always #5 clk = ~clk;

    replay_write_sequencer #(.P(P), .BUFFER_DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .grst        (grst),
        .spk_a       (spk_a),
        .spk_b       (spk_b),
        .wr_idx      (wr_idx),
        .start_count (start_count),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .buf_sel     (buf_sel),
        .short_err   (short_err),
        .late_err    (late_err)
    );

    task automatic check(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            slot++;
        end
    endtask

    // Drop grst; after the edge the window is open and the current slot is 0.
    task automatic open_window();
        grst = 1'b0;
        tick(1);
        slot = 0;
    endtask

    initial begin
        rst   = 1'b1;
        grst  = 1'b1;
        spk_a = '0;
        spk_b = '0;

        // Reset dominates random activity.
        for (int i = 0; i < 3; i++) begin
            grst  = 1'($urandom);
            spk_a = {$urandom, $urandom};
            spk_b = {$urandom, $urandom};
            tick(1);
            check("rst_wr_idx", P'(wr_idx), '0);
            check("rst_flags", P'({start_count, buf_sel, short_err, late_err}), '0);
            check("rst_data", data_in1 | data_in2, '0);
        end
        rst   = 1'b0;
        grst  = 1'b1;
        spk_a = '0;
        spk_b = '0;
        tick(2);
        check("idle_start", P'(start_count), '0);

        // Window 1: first spike, refire drop, rise on the last slot.
        open_window();
        check("s2_start", P'(start_count), 1);
        tick(3);
        spk_a[5] = 1'b1;
        tick(1 + E);
        check("s2_pulse_a", data_in1, P'(1) << 5);
        check("s2_wr_idx", P'(wr_idx), P'(3 + E));
        check("s2_no_b", data_in2, '0);
        check("s2_start_hi", P'(start_count), 1);
        spk_a = '0;
        tick(1);
        check("s2_one_cycle", data_in1, '0);
        tick(9 - slot);
        spk_a[5] = 1'b1;
        tick(1 + E);
        check("s3_refire_drop", data_in1, '0);
        spk_a = '0;
        tick(15 - slot);
        grst = 1'b1;
        tick(1);
        check("s4_bufsel_1", P'(buf_sel), 1);
        check("s4_no_short", P'(short_err), 0);
        check("s4_start_lo", P'(start_count), 0);

        // Window 2: fired mask cleared, full window into HOLD, late edge.
        tick(1);
        open_window();
        tick(2);
        spk_a[5] = 1'b1;
        tick(1 + E);
        check("s3_next_pulse", data_in1, P'(1) << 5);
        check("s3_next_idx", P'(wr_idx), P'(2 + E));
        spk_a = '0;
        tick(15 - slot);
        tick(1);
        check("hold_start", P'(start_count), 1);
        check("hold_wr_idx", P'(wr_idx), P'(15));
        spk_b[63] = 1'b1;
        tick(1 + E);
        check("s6_late_err", P'(late_err), 1);
        check("s6_no_pulse", data_in2, '0);
        spk_b = '0;
        grst = 1'b1;
        tick(1);
        check("s4_bufsel_0", P'(buf_sel), 0);
        check("s4_short_still_0", P'(short_err), 0);
        check("s4_start_lo2", P'(start_count), 0);

        // Window 3: aborted at slot 7.
        open_window();
        tick(7);
        grst = 1'b1;
        tick(1);
        check("s5_short_err", P'(short_err), 1);
        check("s5_bufsel_1", P'(buf_sel), 1);
        check("s5_start_lo", P'(start_count), 0);
        check("s5_wr_idx_hold", P'(wr_idx), P'(7));
        spk_a = '1;
        tick(1 + E);
        check("s5_idle_drop", data_in1, '0);
        spk_a = '0;
        tick(1 + E);

        // Window 4: source B, multi-line slot, sticky flags across a full window.
        open_window();
        spk_b[0] = 1'b1;
        tick(1 + E);
        check("w4_pulse_b0", data_in2, P'(1));
        check("w4_idx_b0", P'(wr_idx), P'(E));
        spk_b = '0;
        tick(4 - slot);
        spk_a = 64'h0000_0000_0000_00F0;
        spk_b = 64'h8000_0000_0000_0001;
        tick(1 + E);
        check("w4_multi_a", data_in1, 64'h0000_0000_0000_00F0);
        check("w4_multi_b", data_in2, 64'h8000_0000_0000_0000);
        check("w4_multi_idx", P'(wr_idx), P'(4 + E));
        spk_a = '0;
        spk_b = '0;
        tick(15 - slot);
        tick(1);
        grst = 1'b1;
        tick(1);
        check("w4_bufsel_0", P'(buf_sel), 0);
        check("w4_late_sticky", P'(late_err), 1);
        check("w4_short_sticky", P'(short_err), 1);

        // Only rst clears the sticky flags.
        rst = 1'b1;
        tick(1);
        check("final_rst_flags", P'({start_count, buf_sel, short_err, late_err}), '0);
        check("final_rst_idx", P'(wr_idx), '0);
        rst = 1'b0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
